// File: rtl/data_memory_ctrl_if.sv
// rtl/data_memory_ctrl_if.sv - data-port bus between the core and the data RAM slave
interface data_memory_ctrl_if;
  logic [31:0] data_address;
  logic        data_cs;
  logic        data_rw;
  logic [1:0]  data_mode;
  logic        data_unsigned;
  logic [31:0] data_wdata;
  logic [31:0] data_rdata;
  logic        data_ready;
  logic        data_fault;

  modport master (
    output data_address, data_cs, data_rw, data_mode, data_unsigned, data_wdata,
    input  data_rdata, data_ready, data_fault
  );

  modport slave (
    input  data_address, data_cs, data_rw, data_mode, data_unsigned, data_wdata,
    output data_rdata, data_ready, data_fault
  );
endinterface

// File: rtl/data_memory_ctrl.sv
// rtl/data_memory_ctrl.sv - big-endian data RAM slave with sub-word read-modify-write
module data_memory_ctrl #(
  parameter logic [31:0] ADDRESS = 32'h80000000,
  parameter int unsigned SIZE    = 4096
) (
  input logic               clk,
  input logic               rst,
  data_memory_ctrl_if.slave bus
);
  localparam int unsigned IDX_W    = (SIZE > 1) ? $clog2(SIZE) : 1;
  localparam logic [31:0] LAST_OFF = 32'(4 * SIZE - 1);

  typedef enum logic [1:0] {S_IDLE, S_RMW, S_RESP} state_e;

  state_e      state_q, state_d;
  logic [31:0] rdata_q, rdata_d;
  logic        fault_q, fault_d;
  logic [31:0] hold_q, hold_d;
  logic [31:0] mem_q [SIZE];

  logic [31:0] offs;
  logic        hit;
  logic        misaligned;
  logic [IDX_W-1:0] idx;
  logic [1:0]  off;
  logic [4:0]  shift;
  logic [31:0] cur, sel, lane_mask, data_mask, merged, load_val;
  logic        mem_we;
  logic [31:0] mem_wdata;

  // Decode and lane arithmetic; the requester holds its inputs through RMW, so
  // these stay valid for the merge without extra capture registers.
  always_comb begin
    offs       = bus.data_address - ADDRESS;
    hit        = bus.data_cs && (bus.data_address >= ADDRESS) && (offs <= LAST_OFF);
    idx        = offs[IDX_W+1:2];
    off        = bus.data_address[1:0];
    misaligned = (bus.data_mode == 2'd3) ||
                 (bus.data_mode == 2'd1 && off[0]) ||
                 (bus.data_mode == 2'd2 && off != 2'd0);
    shift      = (bus.data_mode == 2'd0) ? {~off, 3'b000} : {~off[1], 4'b0000};
    data_mask  = (bus.data_mode == 2'd0) ? 32'h000000FF : 32'h0000FFFF;
    lane_mask  = data_mask << shift;
    cur        = mem_q[idx];
    sel        = cur >> shift;
    merged     = (hold_q & ~lane_mask) | ((bus.data_wdata & data_mask) << shift);
    case (bus.data_mode)
      2'd0:    load_val = bus.data_unsigned ? {24'b0, sel[7:0]} : {{24{sel[7]}}, sel[7:0]};
      2'd1:    load_val = bus.data_unsigned ? {16'b0, sel[15:0]} : {{16{sel[15]}}, sel[15:0]};
      default: load_val = cur;
    endcase
  end

  always_comb begin
    state_d   = state_q;
    rdata_d   = rdata_q;
    fault_d   = fault_q;
    hold_d    = hold_q;
    mem_we    = 1'b0;
    mem_wdata = bus.data_wdata;
    case (state_q)
      S_IDLE: begin
        if (hit) begin
          fault_d = misaligned;
          rdata_d = 32'h0;
          state_d = S_RESP;
          if (!misaligned) begin
            if (!bus.data_rw) begin
              rdata_d = load_val;
            end else if (bus.data_mode == 2'd2) begin
              mem_we = 1'b1;
            end else begin
              hold_d  = cur;
              state_d = S_RMW;
            end
          end
        end
      end
      S_RMW: begin
        mem_we    = 1'b1;
        mem_wdata = merged;
        state_d   = S_RESP;
      end
      S_RESP: begin
        fault_d = 1'b0;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      rdata_q <= 32'h0;
      fault_q <= 1'b0;
      hold_q  <= 32'h0;
    end else begin
      state_q <= state_d;
      rdata_q <= rdata_d;
      fault_q <= fault_d;
      hold_q  <= hold_d;
    end
  end

  // Reset abandons an in-flight RMW, so the write is gated by rst as well.
  always_ff @(posedge clk) begin
    if (mem_we && !rst) begin
      mem_q[idx] <= mem_wdata;
    end
  end

  assign bus.data_ready = (state_q == S_RESP);
  assign bus.data_fault = fault_q;
  assign bus.data_rdata = rdata_q;
endmodule

// File: tb/tb_data_memory_ctrl.sv
// tb/tb_data_memory_ctrl.sv - bench for data_memory_ctrl against a byte-addressed model
module tb_data_memory_ctrl;
  localparam logic [31:0] BASE = 32'h80000000;
  localparam int unsigned SZ   = 4096;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  data_memory_ctrl_if bus ();

  data_memory_ctrl #(.ADDRESS(BASE), .SIZE(SZ)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int total = 0;
  int bad   = 0;

  // Byte-addressed model: each byte address holds one byte, missing entries are zero.
  logic [7:0] mb [logic [31:0]];

  typedef struct {
    logic [31:0] addr;
    logic        rw;
    logic [1:0]  mode;
    logic        uns;
    logic [31:0] wdata;
    logic        hit;
    logic        fault;
    logic [31:0] rdata;
    int          lat;
  } vec_t;

  vec_t vecs [$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  function automatic logic [7:0] rb(input logic [31:0] a);
    return mb.exists(a) ? mb[a] : 8'h00;
  endfunction

  task automatic model_op(input logic [31:0] a, input logic rw, input logic [1:0] m,
                          input logic u, input logic [31:0] wd,
                          output logic hit, output logic flt, output logic [31:0] rd,
                          output int lat);
    longint rel;
    int nb;
    logic [31:0] v;
    rel = longint'(a) - longint'(BASE);
    hit = (rel >= 0) && (rel < longint'(4 * SZ));
    flt = 1'b0;
    rd  = 32'h0;
    lat = 0;
    if (hit) begin
      flt = (m == 2'd3) || (m == 2'd1 && a[0]) || (m == 2'd2 && a[1:0] != 2'd0);
      lat = 1;
      if (!flt) begin
        nb = (m == 2'd0) ? 1 : (m == 2'd1) ? 2 : 4;
        if (rw) begin
          for (int i = 0; i < nb; i++) mb[a + 32'(i)] = 8'(wd >> (8 * (nb - 1 - i)));
          lat = (nb == 4) ? 1 : 2;
        end else begin
          v = 32'h0;
          for (int i = 0; i < nb; i++) v = (v << 8) | {24'h0, rb(a + 32'(i))};
          if (!u && nb == 1) v = {{24{v[7]}}, v[7:0]};
          if (!u && nb == 2) v = {{16{v[15]}}, v[15:0]};
          rd = v;
        end
      end
    end
  endtask

  task automatic run_op(input logic [31:0] a, input logic rw, input logic [1:0] m,
                        input logic u, input logic [31:0] wd,
                        output logic got, output int lat, output logic [31:0] rd,
                        output logic flt, output logic after);
    @(negedge clk);
    bus.data_address  = a;
    bus.data_rw       = rw;
    bus.data_mode     = m;
    bus.data_unsigned = u;
    bus.data_wdata    = wd;
    bus.data_cs       = 1'b1;
    got = 1'b0; lat = 0; rd = 32'h0; flt = 1'b0; after = 1'b0;
    for (int c = 1; c <= 10 && !got; c++) begin
      @(posedge clk); #1;
      if (bus.data_ready) begin
        got = 1'b1; lat = c; rd = bus.data_rdata; flt = bus.data_fault;
      end
    end
    bus.data_cs = 1'b0;
    @(posedge clk); #1;
    after = bus.data_ready;
  endtask

  task automatic exec_check(input string tag, input logic [31:0] a, input logic rw,
                            input logic [1:0] m, input logic u, input logic [31:0] wd,
                            input logic e_hit, input logic e_flt, input logic [31:0] e_rd,
                            input int e_lat);
    logic got, flt, after;
    int lat;
    logic [31:0] rd;
    run_op(a, rw, m, u, wd, got, lat, rd, flt, after);
    check({tag, " ready_seen"}, {31'h0, got}, {31'h0, e_hit});
    if (e_hit && got) begin
      check({tag, " latency"}, 32'(lat), 32'(e_lat));
      check({tag, " fault"}, {31'h0, flt}, {31'h0, e_flt});
      check({tag, " rdata"}, rd, e_rd);
      check({tag, " single_pulse"}, {31'h0, after}, 32'h0);
    end
  endtask

  task automatic add(input logic [31:0] a, input logic rw, input logic [1:0] m, input logic u,
                     input logic [31:0] wd, input logic h, input logic f,
                     input logic [31:0] r, input int l);
    vec_t v;
    v.addr = a; v.rw = rw; v.mode = m; v.uns = u; v.wdata = wd;
    v.hit = h; v.fault = f; v.rdata = r; v.lat = l;
    vecs.push_back(v);
  endtask

  initial begin
    logic h, f, got, flt, after;
    logic [31:0] r, addr;
    int l, lat;
    logic [31:0] rd;

    bus.data_address = 32'h0; bus.data_cs = 1'b0; bus.data_rw = 1'b0;
    bus.data_mode = 2'd0; bus.data_unsigned = 1'b0; bus.data_wdata = 32'h0;

    //    addr          rw    mode  uns   wdata         hit   flt   rdata         lat
    add(32'h80000000, 1'b1, 2'd2, 1'b0, 32'hDEADBEEF, 1'b1, 1'b0, 32'h00000000, 1);
    add(32'h80000000, 1'b0, 2'd2, 1'b0, 32'h0,        1'b1, 1'b0, 32'hDEADBEEF, 1);
    add(32'h80000004, 1'b1, 2'd0, 1'b0, 32'h00000011, 1'b1, 1'b0, 32'h00000000, 2);
    add(32'h80000005, 1'b1, 2'd0, 1'b0, 32'hFFFFFF82, 1'b1, 1'b0, 32'h00000000, 2);
    add(32'h80000006, 1'b1, 2'd0, 1'b0, 32'h00000033, 1'b1, 1'b0, 32'h00000000, 2);
    add(32'h80000007, 1'b1, 2'd0, 1'b0, 32'h000000F4, 1'b1, 1'b0, 32'h00000000, 2);
    add(32'h80000004, 1'b0, 2'd2, 1'b0, 32'h0,        1'b1, 1'b0, 32'h118233F4, 1);
    add(32'h80000005, 1'b0, 2'd0, 1'b0, 32'h0,        1'b1, 1'b0, 32'hFFFFFF82, 1);
    add(32'h80000005, 1'b0, 2'd0, 1'b1, 32'h0,        1'b1, 1'b0, 32'h00000082, 1);
    add(32'h80000008, 1'b1, 2'd2, 1'b0, 32'h00000000, 1'b1, 1'b0, 32'h00000000, 1);
    add(32'h8000000A, 1'b1, 2'd1, 1'b0, 32'h1234BEEF, 1'b1, 1'b0, 32'h00000000, 2);
    add(32'h80000008, 1'b0, 2'd2, 1'b0, 32'h0,        1'b1, 1'b0, 32'h0000BEEF, 1);
    add(32'h8000000A, 1'b0, 2'd1, 1'b0, 32'h0,        1'b1, 1'b0, 32'hFFFFBEEF, 1);
    add(32'h8000000A, 1'b0, 2'd1, 1'b1, 32'h0,        1'b1, 1'b0, 32'h0000BEEF, 1);
    add(32'h80000001, 1'b1, 2'd1, 1'b0, 32'h0000FFFF, 1'b1, 1'b1, 32'h00000000, 1);
    add(32'h80000002, 1'b1, 2'd2, 1'b0, 32'h55555555, 1'b1, 1'b1, 32'h00000000, 1);
    add(32'h80000000, 1'b1, 2'd3, 1'b0, 32'h66666666, 1'b1, 1'b1, 32'h00000000, 1);
    add(32'h80000004, 1'b0, 2'd3, 1'b0, 32'h0,        1'b1, 1'b1, 32'h00000000, 1);
    add(32'h80000000, 1'b0, 2'd2, 1'b0, 32'h0,        1'b1, 1'b0, 32'hDEADBEEF, 1);
    add(32'h80003FFC, 1'b1, 2'd2, 1'b0, 32'hA5A50F8F, 1'b1, 1'b0, 32'h00000000, 1);
    add(32'h80003FFC, 1'b0, 2'd2, 1'b0, 32'h0,        1'b1, 1'b0, 32'hA5A50F8F, 1);
    add(32'h80003FFF, 1'b0, 2'd0, 1'b0, 32'h0,        1'b1, 1'b0, 32'hFFFFFF8F, 1);
    add(32'h80004000, 1'b1, 2'd2, 1'b0, 32'h77777777, 1'b0, 1'b0, 32'h00000000, 0);
    add(32'h7FFFFFFC, 1'b0, 2'd2, 1'b0, 32'h0,        1'b0, 1'b0, 32'h00000000, 0);
    add(32'h80000008, 1'b0, 2'd2, 1'b0, 32'h0,        1'b1, 1'b0, 32'h0000BEEF, 1);

    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    check("reset ready", {31'h0, bus.data_ready}, 32'h0);
    check("reset fault", {31'h0, bus.data_fault}, 32'h0);
    check("reset rdata", bus.data_rdata, 32'h0);

    for (int i = 0; i < vecs.size(); i++) begin
      model_op(vecs[i].addr, vecs[i].rw, vecs[i].mode, vecs[i].uns, vecs[i].wdata, h, f, r, l);
      exec_check($sformatf("vec%0d", i), vecs[i].addr, vecs[i].rw, vecs[i].mode,
                 vecs[i].uns, vecs[i].wdata, vecs[i].hit, vecs[i].fault, vecs[i].rdata,
                 vecs[i].lat);
    end

    // Reset during the RMW cycle of a byte store must leave the word intact.
    model_op(32'h8000000C, 1'b1, 2'd2, 1'b0, 32'h12345678, h, f, r, l);
    exec_check("rmw_pre", 32'h8000000C, 1'b1, 2'd2, 1'b0, 32'h12345678, 1'b1, 1'b0, 32'h0, 1);
    @(negedge clk);
    bus.data_address = 32'h8000000C; bus.data_rw = 1'b1; bus.data_mode = 2'd0;
    bus.data_unsigned = 1'b0; bus.data_wdata = 32'h000000AA; bus.data_cs = 1'b1;
    @(posedge clk); #1;
    check("rmw ready_in_rmw", {31'h0, bus.data_ready}, 32'h0);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    bus.data_cs = 1'b0;
    got = 1'b0;
    for (int c = 0; c < 6; c++) begin
      if (bus.data_ready) got = 1'b1;
      @(posedge clk); #1;
    end
    check("rmw no_ready", {31'h0, got}, 32'h0);
    exec_check("rmw_reload", 32'h8000000C, 1'b0, 2'd2, 1'b0, 32'h0, 1'b1, 1'b0, 32'h12345678, 1);

    // Seed the random region with known words, then random traffic against the model.
    for (int w = 0; w < 16; w++) begin
      addr = 32'h80000100 + 32'(4 * w);
      r = $urandom;
      model_op(addr, 1'b1, 2'd2, 1'b0, r, h, f, rd, l);
      run_op(addr, 1'b1, 2'd2, 1'b0, r, got, lat, rd, flt, after);
    end
    for (int w = 0; w < 4; w++) begin
      addr = 32'h80003FF0 + 32'(4 * w);
      r = $urandom;
      model_op(addr, 1'b1, 2'd2, 1'b0, r, h, f, rd, l);
      run_op(addr, 1'b1, 2'd2, 1'b0, r, got, lat, rd, flt, after);
    end
    for (int n = 0; n < 250; n++) begin
      logic rw, u;
      logic [1:0] m;
      logic [31:0] wd;
      case ($urandom_range(0, 9))
        0:       addr = 32'h80004000 + 32'($urandom_range(0, 7));
        1:       addr = 32'h7FFFFFF8 + 32'($urandom_range(0, 7));
        2, 3:    addr = 32'h80003FF0 + 32'($urandom_range(0, 15));
        default: addr = 32'h80000100 + 32'($urandom_range(0, 63));
      endcase
      rw = 1'($urandom_range(0, 1));
      m  = 2'($urandom_range(0, 3));
      u  = 1'($urandom_range(0, 1));
      wd = $urandom;
      model_op(addr, rw, m, u, wd, h, f, r, l);
      exec_check($sformatf("rnd%0d", n), addr, rw, m, u, wd, h, f, r, l);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
